// File: rtl/daq_frame_packer_if.sv
// FIFO write-side bus between daq_frame_packer and the USB async FIFO.
// Signal names match the legacy flat ports for drop-in compatibility.
interface daq_frame_packer_if;
   logic        fifo_wrreq_o;
   logic [15:0] fifo_data_o;
   logic        fifo_full_i;

   modport master (output fifo_wrreq_o, output fifo_data_o, input fifo_full_i);
   modport slave  (input fifo_wrreq_o, input fifo_data_o, output fifo_full_i);
endinterface

// File: rtl/daq_frame_packer.sv
// Multi-channel ADC capture, sample-set queue and framed 16-bit writer into the USB FIFO.
// Optional FRAME_CSUM_EN appends a modulo-2^16 payload sum as a frame trailer.
module daq_frame_packer #(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned CH_NUM     = 1,
   parameter int unsigned FRAME_SETS = 256,
   parameter int unsigned QDEPTH     = 4,
   parameter logic [15:0] SYNC_WORD  = 16'hA55A
) (
   input  logic                     adc_clk,
   input  logic                     rst_n_i,
   input  logic [CH_NUM*DATA_W-1:0] ad_data_i,
   input  logic [CH_NUM-1:0]        ad_otr_i,
   input  logic                     ad_valid_i,
   input  logic                     cap_en_i,
   input  logic                     test_mode_i,
   input  logic                     clr_i,
   daq_frame_packer_if.master       fifo,
   output logic                     busy_o,
   output logic [15:0]              drop_cnt_o,
   output logic [15:0]              frame_cnt_o
);
   localparam int unsigned AW = $clog2(QDEPTH);
   localparam int unsigned SW = (FRAME_SETS > 1) ? $clog2(FRAME_SETS) : 1;
   localparam logic [AW:0]   PTR_ONE  = 1;
   localparam logic [SW-1:0] SET_ONE  = 1;
   localparam logic [SW-1:0] LAST_SET = SW'(FRAME_SETS - 1);
   localparam logic [2:0]    LAST_CH  = 3'(CH_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_SEQ, S_PAYLOAD
`ifdef FRAME_CSUM_EN
      , S_CSUM
`endif
   } state_e;

   state_e state_q, state_d;
   logic   cap_gate_q, cap_gate_d;

   logic [CH_NUM*DATA_W-1:0] q_data_q [QDEPTH];
   logic [CH_NUM-1:0]        q_otr_q  [QDEPTH];
   logic [AW:0]              wr_ptr_q, rd_ptr_q;
   logic                     q_empty, q_full;
   logic [CH_NUM*DATA_W-1:0] head_data, enq_data;
   logic [CH_NUM-1:0]        head_otr, enq_otr;

   logic [DATA_W-1:0] tcnt_q;
   logic [2:0]        ch_idx_q;
   logic [SW-1:0]     set_cnt_q;
   logic [15:0]       seq_q, frame_cnt_q, drop_cnt_q;
   logic              wrreq_q;
   logic [15:0]       wdata_q;
`ifdef FRAME_CSUM_EN
   logic [15:0]       csum_q;
`endif

   logic              gate, enq_req, enq, drop, issue, pop, frame_done, otr;
   logic [DATA_W-1:0] sample;
   logic [15:0]       word;

   assign q_empty   = (wr_ptr_q == rd_ptr_q);
   assign q_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_data = q_data_q[rd_ptr_q[AW-1:0]];
   assign head_otr  = q_otr_q[rd_ptr_q[AW-1:0]];

   // In IDLE the gate follows cap_en_i directly; inside a frame it is frozen.
   assign gate    = (state_q == S_IDLE) ? cap_en_i : cap_gate_q;
   assign enq_req = ad_valid_i & gate;
   assign enq     = enq_req & (~q_full | pop);
   assign drop    = enq_req & q_full & ~pop;

   always_comb begin
      enq_data = ad_data_i;
      enq_otr  = ad_otr_i;
      if (test_mode_i) begin
         enq_otr = '0;
         for (int unsigned c = 0; c < CH_NUM; c++)
            enq_data[c*DATA_W +: DATA_W] = tcnt_q + DATA_W'(c);
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         cap_gate_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cap_gate_q <= cap_gate_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cap_gate_d = (state_q == S_IDLE) ? cap_en_i : cap_gate_q;
      case (state_q)
         S_IDLE:    if (!q_empty) state_d = S_SYNC;
         S_SYNC:    if (issue) state_d = S_SEQ;
         S_SEQ:     if (issue) state_d = S_PAYLOAD;
         S_PAYLOAD: if (pop && set_cnt_q == LAST_SET) begin
`ifdef FRAME_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
`endif
         end
`ifdef FRAME_CSUM_EN
         S_CSUM:    if (issue) state_d = S_IDLE;
`endif
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      issue      = 1'b0;
      pop        = 1'b0;
      frame_done = 1'b0;
      word       = '0;
      sample     = '0;
      otr        = 1'b0;
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         if (ch_idx_q == 3'(c)) begin
            sample = head_data[c*DATA_W +: DATA_W];
            otr    = head_otr[c];
         end
      end
      case (state_q)
         S_SYNC: begin
            issue = ~fifo.fifo_full_i;
            word  = SYNC_WORD;
         end
         S_SEQ: begin
            issue = ~fifo.fifo_full_i;
            word  = seq_q;
         end
         S_PAYLOAD: begin
            issue              = ~q_empty & ~fifo.fifo_full_i;
            word[15]           = otr;
            word[14:12]        = ch_idx_q;
            word[DATA_W-1:0]   = sample;
            pop                = issue && (ch_idx_q == LAST_CH);
`ifndef FRAME_CSUM_EN
            frame_done         = pop && (set_cnt_q == LAST_SET);
`endif
         end
`ifdef FRAME_CSUM_EN
         S_CSUM: begin
            issue      = ~fifo.fifo_full_i;
            word       = csum_q;
            frame_done = issue;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge adc_clk) begin
      if (enq) begin
         q_data_q[wr_ptr_q[AW-1:0]] <= enq_data;
         q_otr_q[wr_ptr_q[AW-1:0]]  <= enq_otr;
      end
   end

   always_ff @(posedge adc_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         tcnt_q      <= '0;
         ch_idx_q    <= '0;
         set_cnt_q   <= '0;
         seq_q       <= '0;
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         wrreq_q     <= 1'b0;
         wdata_q     <= '0;
`ifdef FRAME_CSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         if (enq) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            tcnt_q   <= tcnt_q + DATA_W'(1);
         end
         if (pop) begin
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            set_cnt_q <= (set_cnt_q == LAST_SET) ? '0 : set_cnt_q + SET_ONE;
         end
         if (issue && state_q == S_PAYLOAD)
            ch_idx_q <= (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + 3'd1;
         if (frame_done)
            seq_q <= seq_q + 16'd1;
         if (clr_i)
            frame_cnt_q <= '0;
         else if (frame_done)
            frame_cnt_q <= frame_cnt_q + 16'd1;
         if (clr_i)
            drop_cnt_q <= '0;
         else if (drop && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 16'd1;
         wrreq_q <= issue;
         if (issue)
            wdata_q <= word;
`ifdef FRAME_CSUM_EN
         if (state_q == S_IDLE)
            csum_q <= '0;
         else if (issue && state_q == S_PAYLOAD)
            csum_q <= csum_q + word;
`endif
      end
   end

   assign fifo.fifo_wrreq_o = wrreq_q;
   assign fifo.fifo_data_o  = wdata_q;
   assign busy_o            = (state_q != S_IDLE) || !q_empty;
   assign drop_cnt_o        = drop_cnt_q;
   assign frame_cnt_o       = frame_cnt_q;
endmodule
